// File: rtl/isi_pkg.sv
// Shared constants for the ISI adder pipeline.
//   ISI_W_DEFAULT  default per-lane ISI width
//   SAT_HOLD/CLAMP overflow policy encodings for SAT_MODE
//   OVF_CNT_W      width of the optional overflow counter (ISI_PLUS_OVF_CNT_EN)
package isi_pkg;

  localparam int unsigned ISI_W_DEFAULT = 8;
  localparam int unsigned SAT_HOLD      = 0;
  localparam int unsigned SAT_CLAMP     = 1;
  localparam int unsigned OVF_CNT_W     = 16;

endpackage

// File: rtl/isi_plus_lane.sv
// One ISI adder lane: sum, overflow detect, hold-last register, z_valid gating.
// Ports:
//   clk, clr_n    clock, async active-low reset
//   load          a beat moves from stage 1 into this lane's output registers
//   x, y          stage-1 operands
//   cx, cy        stage-1 pending address-compare flags
//   z             registered lane result
//   z_valid       registered: no overflow and neither compare flag set
//   ovf           registered: (BIT_ISI+1)-bit sum exceeded 2**BIT_ISI-1
module isi_plus_lane
  import isi_pkg::*;
#(
  parameter int unsigned BIT_ISI  = ISI_W_DEFAULT,
  parameter int unsigned SAT_MODE = SAT_HOLD
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic [BIT_ISI-1:0] x,
  input  logic [BIT_ISI-1:0] y,
  input  logic               cx,
  input  logic               cy,
  output logic [BIT_ISI-1:0] z,
  output logic               z_valid,
  output logic               ovf
);

  logic [BIT_ISI:0]   sum_c;
  logic               ovf_c;
  logic [BIT_ISI-1:0] z_next_c;
  logic [BIT_ISI-1:0] hold_last;

  assign sum_c = {1'b0, x} + {1'b0, y};
  assign ovf_c = sum_c[BIT_ISI];

  // Overflow policy: clamp to all-ones or repeat the last good sum.
  always_comb begin
    z_next_c = sum_c[BIT_ISI-1:0];
    if (ovf_c) begin
      z_next_c = (SAT_MODE == SAT_CLAMP) ? '1 : hold_last;
    end
  end

  // Output and hold-last registers; hold_last only tracks good sums.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      z         <= '0;
      z_valid   <= 1'b0;
      ovf       <= 1'b0;
      hold_last <= '0;
    end else if (load) begin
      z       <= z_next_c;
      z_valid <= !ovf_c && !cx && !cy;
      ovf     <= ovf_c;
      if (!ovf_c) begin
        hold_last <= sum_c[BIT_ISI-1:0];
      end
    end
  end

endmodule

// File: rtl/isi_plus_pipe.sv
// N-channel ISI adder, two-stage valid/ready pipeline with full backpressure.
// Optional feature macro: ISI_PLUS_OVF_CNT_EN adds ovf_cnt (saturating count of
// overflowed lanes over delivered beats).
// Ports:
//   clk, clr_n               clock, async active-low reset
//   in_valid / in_ready      input handshake (in_ready combinational from out_ready)
//   isi_x, isi_y             packed lane operands, lane i = [i*BIT_ISI +: BIT_ISI]
//   comp_addr_x/_y           per-lane pending address-compare flags
//   out_valid / out_ready    output handshake
//   isi_z, z_valid, ovf      registered per-lane results
//   ovf_cnt                  (ISI_PLUS_OVF_CNT_EN only) overflow lane counter
module isi_plus_pipe
  import isi_pkg::*;
#(
  parameter int unsigned BIT_ISI  = ISI_W_DEFAULT,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SAT_MODE = SAT_HOLD
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH*BIT_ISI-1:0] isi_x,
  input  logic [N_CH*BIT_ISI-1:0] isi_y,
  input  logic [N_CH-1:0]         comp_addr_x,
  input  logic [N_CH-1:0]         comp_addr_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*BIT_ISI-1:0] isi_z,
  output logic [N_CH-1:0]         z_valid,
  output logic [N_CH-1:0]         ovf
`ifdef ISI_PLUS_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]    ovf_cnt
`endif
);

  logic                    run;
  logic                    s1_full;
  logic [N_CH*BIT_ISI-1:0] s1_x;
  logic [N_CH*BIT_ISI-1:0] s1_y;
  logic [N_CH-1:0]         s1_cx;
  logic [N_CH-1:0]         s1_cy;
  logic                    s2_load_c;
  logic                    s1_adv_c;
  logic                    accept_c;

  // Handshake: S2 loads when empty or drained; S1 advances into it.
  assign s2_load_c = !out_valid || out_ready;
  assign s1_adv_c  = s1_full && s2_load_c;
  assign in_ready  = run && (!s1_full || s1_adv_c);
  assign accept_c  = in_valid && in_ready;

  // run holds in_ready low through reset and rises on the first clock after.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      run       <= 1'b0;
      s1_full   <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_cx     <= '0;
      s1_cy     <= '0;
      out_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept_c) begin
        s1_full <= 1'b1;
        s1_x    <= isi_x;
        s1_y    <= isi_y;
        s1_cx   <= comp_addr_x;
        s1_cy   <= comp_addr_y;
      end else if (s1_adv_c) begin
        s1_full <= 1'b0;
      end
      if (s2_load_c) begin
        out_valid <= s1_full;
      end
    end
  end

  // Per-lane datapath; lane registers load only on a real S1->S2 move.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    isi_plus_lane #(
      .BIT_ISI  (BIT_ISI),
      .SAT_MODE (SAT_MODE)
    ) u_lane (
      .clk     (clk),
      .clr_n   (clr_n),
      .load    (s1_adv_c),
      .x       (s1_x[i*BIT_ISI +: BIT_ISI]),
      .y       (s1_y[i*BIT_ISI +: BIT_ISI]),
      .cx      (s1_cx[i]),
      .cy      (s1_cy[i]),
      .z       (isi_z[i*BIT_ISI +: BIT_ISI]),
      .z_valid (z_valid[i]),
      .ovf     (ovf[i])
    );
  end

`ifdef ISI_PLUS_OVF_CNT_EN
  localparam int unsigned POP_W = $clog2(N_CH + 1);

  logic [POP_W-1:0]   pop_c;
  logic [OVF_CNT_W:0] cnt_sum_c;

  // Popcount of overflowed lanes, summed one bit wider to catch wrap.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_c = pop_c + POP_W'(ovf[i]);
    end
    cnt_sum_c = {1'b0, ovf_cnt} + (OVF_CNT_W+1)'(pop_c);
  end

  // Saturating counter, advanced per delivered beat.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      ovf_cnt <= cnt_sum_c[OVF_CNT_W] ? '1 : cnt_sum_c[OVF_CNT_W-1:0];
    end
  end
`endif

endmodule
